// File: rtl/signal_freq_meter.sv
// Gated-window frequency meter: counts synchronised sig_i rising edges per window.
// Define FREQ_METER_PERIOD_EN to add edge-to-edge period measurement.
module signal_freq_meter #(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int GATE_HZ   = 10,
    parameter int CNT_WIDTH = 24
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 sig_i,
    input  logic                 en_i,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 valid_o,
    output logic                 ovf_o,
    output logic [CNT_WIDTH-1:0] period_o,
    output logic                 period_valid_o
);

    localparam int GATE_CYCLES = CLK_FREQ / GATE_HZ;
    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE,
        MEASURE
    } state_e;

    state_e               state_q, state_d;
    logic                 sync1_q, sync2_q, sync3_q, edge_q;
    logic [GW-1:0]        gate_q, gate_d;
    logic [CNT_WIDTH-1:0] ecnt_q, ecnt_d;
    logic                 eovf_q, eovf_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 valid_q, valid_d;
    logic [CNT_WIDTH-1:0] edge_sat;
    logic                 edge_ovf;

    // sync3_q is the delayed copy; edge_q lands three clocks after sig_i rises
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= sig_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            edge_q  <= sync2_q & ~sync3_q;
        end
    end

    assign edge_ovf = edge_q & (ecnt_q == CNT_MAX);
    assign edge_sat = (edge_q && ecnt_q != CNT_MAX) ? ecnt_q + 1'b1 : ecnt_q;

    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        ecnt_d  = ecnt_q;
        eovf_d  = eovf_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                gate_d = '0;
                ecnt_d = '0;
                eovf_d = 1'b0;
                if (en_i) state_d = MEASURE;
            end
            MEASURE: begin
                if (!en_i) begin
                    state_d = IDLE;
                    gate_d  = '0;
                    ecnt_d  = '0;
                    eovf_d  = 1'b0;
                end else if (gate_q == GATE_LAST) begin
                    gate_d  = '0;
                    count_d = edge_sat;
                    ovf_d   = eovf_q | edge_ovf;
                    valid_d = 1'b1;
                    ecnt_d  = '0;
                    eovf_d  = 1'b0;
                end else begin
                    gate_d = gate_q + 1'b1;
                    ecnt_d = edge_sat;
                    eovf_d = eovf_q | edge_ovf;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gate_q  <= '0;
            ecnt_q  <= '0;
            eovf_q  <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            ecnt_q  <= ecnt_d;
            eovf_q  <= eovf_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign count_o = count_q;
    assign ovf_o   = ovf_q;
    assign valid_o = valid_q;

`ifdef FREQ_METER_PERIOD_EN
    logic [CNT_WIDTH-1:0] pcnt_q, pcnt_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic                 armed_q, armed_d;
    logic                 pvalid_q, pvalid_d;

    // first edge in a measurement only arms; later edges report the gap
    always_comb begin
        pcnt_d   = pcnt_q;
        period_d = period_q;
        armed_d  = armed_q;
        pvalid_d = 1'b0;
        if (state_q == MEASURE && en_i) begin
            if (edge_q) begin
                if (armed_q) begin
                    period_d = (pcnt_q == CNT_MAX) ? CNT_MAX : pcnt_q + 1'b1;
                    pvalid_d = 1'b1;
                end
                pcnt_d  = '0;
                armed_d = 1'b1;
            end else if (pcnt_q != CNT_MAX) begin
                pcnt_d = pcnt_q + 1'b1;
            end
        end else begin
            pcnt_d  = '0;
            armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcnt_q   <= '0;
            period_q <= '0;
            armed_q  <= 1'b0;
            pvalid_q <= 1'b0;
        end else begin
            pcnt_q   <= pcnt_d;
            period_q <= period_d;
            armed_q  <= armed_d;
            pvalid_q <= pvalid_d;
        end
    end

    assign period_o       = period_q;
    assign period_valid_o = pvalid_q;
`else
    assign period_o       = '0;
    assign period_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_signal_freq_meter.sv
// Directed bench for signal_freq_meter: window counts, terminal-edge,
// enable drop, reset mid-window, saturation and period output.
module tb_signal_freq_meter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       sig;
    logic [7:0] count8;
    logic       valid8;
    logic       ovf8;
    logic [7:0] period8;
    logic       pvalid8;
    logic [4:0] count5;
    logic       valid5;
    logic       ovf5;
    logic [4:0] period5;
    logic       pvalid5;

    int checks   = 0;
    int failures = 0;
    int pv_seen  = 0;

    int   per      = 0;
    int   hi       = 0;
    int   ph       = 0;
    int   last_per = 0;
    logic wave     = 1'b0;
    logic sig_man  = 1'b0;

    signal_freq_meter #(
        .CLK_FREQ (1000),
        .GATE_HZ  (10),
        .CNT_WIDTH(8)
    ) u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .sig_i         (sig),
        .en_i          (en),
        .count_o       (count8),
        .valid_o       (valid8),
        .ovf_o         (ovf8),
        .period_o      (period8),
        .period_valid_o(pvalid8)
    );

    signal_freq_meter #(
        .CLK_FREQ (1000),
        .GATE_HZ  (10),
        .CNT_WIDTH(5)
    ) u_dut5 (
        .clk_i         (clk),
        .rst_i         (rst),
        .sig_i         (sig),
        .en_i          (en),
        .count_o       (count5),
        .valid_o       (valid5),
        .ovf_o         (ovf5),
        .period_o      (period5),
        .period_valid_o(pvalid5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign sig = (per == 0) ? sig_man : wave;

    // free-running square wave: period per cycles, high for hi cycles
    initial forever begin
        @(negedge clk);
        if (per != last_per) begin
            last_per = per;
            ph = 0;
        end else if (per != 0) begin
            ph = (ph + 1 >= per) ? 0 : ph + 1;
        end
        wave = (per != 0) && (ph < hi);
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (pvalid8) pv_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            #1;
            if (valid8) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_pvalid(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            #1;
            if (pvalid8) begin
                n = i;
                break;
            end
        end
    endtask

    int n;
    int nv;

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", count8, 0);
        chk("rst_valid", valid8, 0);
        chk("rst_ovf", ovf8, 0);
        chk("rst_period", period8, 0);
        chk("rst_pvalid", pvalid8, 0);

        // steady 10-cycle wave
        @(negedge clk);
        rst = 1'b0;
        hi  = 5;
        per = 10;
        repeat (50) @(negedge clk);
        en = 1'b1;
        wait_valid(300, n);
        chk("sq_first_lat", n, 101);
        chk("sq_count0", count8, 10);
        chk("sq_ovf0", ovf8, 0);
        chk("sq_count5", count5, 10);
        @(posedge clk);
        #1;
        chk("valid_one_cycle", valid8, 0);
        wait_valid(300, n);
        chk("sq_gap1", n, 99);
        chk("sq_count1", count8, 10);
        chk("sq_ovf1", ovf8, 0);
        wait_valid(300, n);
        chk("sq_gap2", n, 100);
        chk("sq_count2", count8, 10);

        // toggle every cycle: 50 edges per window
        @(negedge clk);
        hi  = 1;
        per = 2;
        wait_valid(300, n);
        wait_valid(300, n);
        chk("fast_count8", count8, 50);
        chk("fast_ovf8", ovf8, 0);
        chk("fast_count5", count5, 31);
        chk("fast_ovf5", ovf5, 1);
        @(negedge clk);
        sig_man = 1'b0;
        per     = 0;
        wait_valid(300, n);
        wait_valid(300, n);
        chk("static_count8", count8, 0);
        chk("static_count5", count5, 0);
        chk("static_ovf5", ovf5, 0);

        // single rise whose edge pulse lands on gate cycle 99
        repeat (96) @(posedge clk);
        @(negedge clk);
        sig_man = 1'b1;
        wait_valid(300, n);
        chk("term_lat", n, 4);
        chk("term_count", count8, 1);
        wait_valid(300, n);
        chk("term_gap", n, 100);
        chk("term_next", count8, 0);
        @(negedge clk);
        sig_man = 1'b0;

        // enable dropped at gate cycle 50 for 20 cycles
        hi  = 5;
        per = 10;
        wait_valid(300, n);
        repeat (49) @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        nv = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (valid8) nv++;
        end
        chk("en_drop_novalid", nv, 0);
        @(negedge clk);
        en = 1'b1;
        wait_valid(300, n);
        chk("en_restart_lat", n, 101);
        chk("en_restart_count", count8, 10);

        // reset at gate cycle 60
        repeat (59) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_count", count8, 0);
        chk("midrst_valid", valid8, 0);
        chk("midrst_ovf", ovf8, 0);
        chk("midrst_period", period8, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_valid(300, n);
        chk("midrst_lat", n, 101);
        chk("midrst_after", count8, 10);

        // 17-cycle period
        @(negedge clk);
        en  = 1'b0;
        hi  = 8;
        per = 17;
        repeat (40) @(negedge clk);
        en = 1'b1;
`ifdef FREQ_METER_PERIOD_EN
        wait_pvalid(200, n);
        chk("per_arm_first", n > 17, 1);
        chk("per_val0", period8, 17);
        wait_pvalid(200, n);
        chk("per_gap", n, 17);
        chk("per_val1", period8, 17);
        wait_pvalid(200, n);
        chk("per_val2", period8, 17);
`else
        repeat (200) @(posedge clk);
        #1;
        chk("noper_period", period8, 0);
        chk("noper_pvalid_seen", pv_seen, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/signal_freq_meter.md
SIGNAL_FREQ_METER -- requirements
Module: signal_freq_meter

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 25_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter GATE_HZ, default 10, gate windows per second; window length GATE_CYCLES = CLK_FREQ/GATE_HZ clock cycles.
REQ-003 SHALL have parameter CNT_WIDTH, default 24, width of edge-count and period results.
REQ-004 SHALL have port clk_i, input, 1, the single system clock.
REQ-005 SHALL have port rst_i, input, 1, reset: synchronous, active-high.
REQ-006 SHALL have port sig_i, input, 1, measured signal, asynchronous to clk_i.
REQ-007 SHALL have port en_i, input, 1, measurement enable.
REQ-008 SHALL have port count_o, output, CNT_WIDTH, rising edges counted in last completed window.
REQ-009 SHALL have port valid_o, output, 1, one-cycle pulse when count_o updates.
REQ-010 SHALL have port ovf_o, output, 1, saturation flag of last completed window.
REQ-011 SHALL have port period_o, output, CNT_WIDTH, clk_i cycles between the last two sig_i rising edges.
REQ-012 SHALL have port period_valid_o, output, 1, one-cycle pulse when period_o updates.

Function
REQ-013 SHALL synchronise sig_i through two flops, then detect rising edge as sync2 high and delayed copy low; edge pulse asserts 3 cycles after sig_i rises.
REQ-014 SHALL implement states IDLE and MEASURE; IDLE->MEASURE on en_i high, MEASURE->IDLE on en_i low, any state->IDLE on rst_i.
REQ-015 In IDLE: gate counter and edge counter SHALL be held at 0; count_o, ovf_o, period_o hold last values; valid_o and period_valid_o low.
REQ-016 In MEASURE the gate counter SHALL run 0..GATE_CYCLES-1 and wrap to 0.
REQ-017 Each edge pulse in MEASURE SHALL increment the edge counter, saturating at all-ones and setting an internal overflow bit.
REQ-018 On the gate-counter terminal cycle SHALL load count_o with edge counter plus that cycle's edge (saturated), load ovf_o with overflow bit, pulse valid_o next cycle-edge for exactly 1 cycle, and clear edge counter and overflow bit; an edge on the terminal cycle is counted in the closing window, never lost or doubled.
REQ-019 en_i falling mid-window SHALL discard the partial window with no valid_o pulse; the next en_i rise starts a full fresh window.
REQ-020 Widths: GATE counter width SHALL be $clog2(GATE_CYCLES); no truncation of GATE_CYCLES allowed.

Reset
REQ-021 On rst_i high at a clk_i edge: state IDLE, synchroniser flops 0, all counters 0, count_o 0, ovf_o 0, valid_o 0, period_o 0, period_valid_o 0.
REQ-022 Reset mid-window SHALL drop the window; no valid_o pulse may follow reset release until a full window completes.

Configuration
REQ-023 Macro FREQ_METER_PERIOD_EN SHALL compile in period measurement.
REQ-024 With FREQ_METER_PERIOD_EN: in MEASURE a cycle counter SHALL count since last edge (saturating); on an edge, if armed, period_o <= counter+1 and period_valid_o pulses 1 cycle; counter resets to 0; first edge after entering MEASURE only arms, producing no period.
REQ-025 Without FREQ_METER_PERIOD_EN: period_o and period_valid_o SHALL be constant 0; ports remain.

Verification (CLK_FREQ=1000, GATE_HZ=10, GATE_CYCLES=100, CNT_WIDTH=8 unless stated)
REQ-026 sig_i square wave period 10 cycles, en_i held high -> every 100 cycles valid_o pulses with count_o=10, ovf_o=0.
REQ-027 sig_i toggling every cycle (period 2), CNT_WIDTH=5 -> count_o=31, ovf_o=1; following window with sig_i static -> count_o=0, ovf_o=0.
REQ-028 Single sig_i rise timed so its edge pulse lands on gate cycle 99 -> that window count_o=1, next window count_o=0.
REQ-029 en_i dropped at gate cycle 50 then raised 20 cycles later -> no valid_o until 100 cycles after re-enable; count reflects only new window.
REQ-030 rst_i asserted at gate cycle 60 -> all outputs 0 next cycle; no valid_o before a full window after release.
REQ-031 With FREQ_METER_PERIOD_EN, sig_i period 17 -> first edge no pulse; subsequent edges period_valid_o with period_o=17; without macro period_o stays 0.
